// File: rtl/antares_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : antares_ifetch_unit
//  Description : Instruction-fetch port between the PC register, the IF/ID
//                register and the instruction bus. Holds the bus stable
//                while a request is outstanding, buffers data while decode
//                is stalled, and drains requests abandoned by a flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module antares_ifetch_unit #(
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        id_stall,
    input  logic        if_flush,
    output logic [31:0] if_instruction,
    output logic        if_inst_valid,
    output logic        if_exc_address_if,
    output logic        if_stall,
    output logic [31:0] imem_address,
    output logic        imem_request,
    input  logic        imem_ready,
    input  logic [31:0] imem_data
);

    localparam logic [1:0] c_ISSUE = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_addr;
    logic [31:0] r_buf;
    logic        w_aligned;
    logic        w_load_addr;
    logic        w_load_buf;

    assign w_aligned = (if_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ISSUE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr <= 32'h0;
            r_buf  <= 32'h0;
        end else begin
            if (w_load_addr) r_addr <= if_pc;
            if (w_load_buf)  r_buf  <= imem_data;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_addr  = 1'b0;
        w_load_buf   = 1'b0;
        case (r_state)
            c_ISSUE: begin
                if (!if_flush && w_aligned) begin
                    if (imem_ready) begin
                        if (id_stall) begin
                            w_next_state = c_HOLD;
                            w_load_buf   = 1'b1;
                        end
                    end else begin
                        w_next_state = c_WAIT;
                        w_load_addr  = 1'b1;
                    end
                end
            end
            c_WAIT: begin
                if (imem_ready) begin
                    if (!if_flush && id_stall) begin
                        w_next_state = c_HOLD;
                        w_load_buf   = 1'b1;
                    end else begin
                        w_next_state = c_ISSUE;
                    end
                end else if (if_flush) begin
                    // The redirect target loads now; the old response is still owed.
                    w_next_state = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (imem_ready) w_next_state = c_ISSUE;
            end
            c_HOLD: begin
                if (if_flush || !id_stall) w_next_state = c_ISSUE;
            end
            default: w_next_state = c_ISSUE;
        endcase
    end

    always_comb begin
        imem_request      = 1'b0;
        imem_address      = if_pc;
        if_instruction    = imem_data;
        if_inst_valid     = 1'b0;
        if_exc_address_if = 1'b0;
        case (r_state)
            c_ISSUE: begin
                imem_request = !if_flush && w_aligned;
                if (!if_flush && !w_aligned) begin
                    if_exc_address_if = 1'b1;
                    if_inst_valid     = 1'b1;
                    if_instruction    = NOP_INSTRUCTION;
                end else if (imem_request && imem_ready) begin
                    if_inst_valid = 1'b1;
                end
            end
            c_WAIT: begin
                imem_request  = 1'b1;
                imem_address  = r_addr;
                if_inst_valid = imem_ready && !if_flush;
            end
            c_DRAIN: begin
                imem_request = 1'b1;
                imem_address = r_addr;
            end
            c_HOLD: begin
                if_instruction = r_buf;
                if_inst_valid  = !if_flush;
            end
            default: ;
        endcase

        if (!rst) begin
            imem_request      = 1'b0;
            if_inst_valid     = 1'b0;
            if_exc_address_if = 1'b0;
            if_stall          = 1'b1;
        end else begin
            if_stall = if_flush ? 1'b0 : (!if_inst_valid || id_stall);
        end
    end

endmodule
`default_nettype wire

// File: doc/antares_ifetch_unit.md
Name: antares_ifetch_unit

Overview:
Instruction-fetch port that consumes the program counter and drives the instruction-memory bus. It issues one request per PC, waits for the memory response, and buffers the instruction when decode is stalled. It generates `if_stall` back to the PC register and handles flushes and misaligned PCs. It sits between the PC register, the IF/ID pipeline register and the instruction bus.

Parameters:
NOP_INSTRUCTION, 32'h0000_0000, instruction word presented with a fetch exception.

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-low (reset when 0)
if_pc  input  32  current PC from PC register
id_stall  input  1  decode cannot accept an instruction this cycle
if_flush  input  1  branch/exception redirect; PC register loads new PC this cycle
if_instruction  output  32  instruction to IF/ID
if_inst_valid  output  1  if_instruction valid this cycle
if_exc_address_if  output  1  fetch-address exception (if_pc[1:0] != 0)
if_stall  output  1  hold PC register
imem_address  output  32  instruction-bus address
imem_request  output  1  instruction-bus request
imem_ready  input  1  response valid; imem_data valid same cycle
imem_data  input  32  read data

Behaviour:
- Bus rule: once imem_request=1 without imem_ready, request and address must stay stable until imem_ready. Zero-wait responses are allowed: ready may arrive in the issue cycle.
- States: ISSUE, WAIT, HOLD, DRAIN. Registers: state, addr_q[31:0], buf_q[31:0].
- Reset (rst=0 at posedge): state=ISSUE, addr_q=0, buf_q=0. While rst=0: imem_request=0, if_inst_valid=0, if_exc_address_if=0, if_stall=1. Any in-flight transaction is abandoned.
- if_stall = if_flush ? 0 : (!if_inst_valid | id_stall).
- ISSUE:
  - imem_address=if_pc.
  - imem_request = !if_flush & (if_pc[1:0]==0).
  - Misaligned PC (no flush): no request; if_exc_address_if=1, if_inst_valid=1, if_instruction=NOP_INSTRUCTION; stay ISSUE.
  - ready & !if_flush: if_instruction=imem_data, if_inst_valid=1. If id_stall, buf_q<=imem_data and go HOLD; else stay ISSUE (PC advances).
  - ready & if_flush: not possible, because request is gated.
  - !ready with request: addr_q<=if_pc, go WAIT.
- WAIT:
  - imem_request=1, imem_address=addr_q.
  - ready & !if_flush: deliver as in ISSUE (HOLD if id_stall, else ISSUE).
  - ready & if_flush: discard data, if_inst_valid=0, go ISSUE.
  - !ready & if_flush: go DRAIN. if_stall=0, so the PC register takes the redirect target.
  - !ready & !if_flush: stay WAIT.
- DRAIN:
  - imem_request=1, imem_address=addr_q, if_inst_valid=0, so if_stall=1.
  - ready: discard data, go ISSUE.
  - if_flush in DRAIN: stay DRAIN. if_stall=0 lets the newest target load.
- HOLD:
  - imem_request=0, if_instruction=buf_q, if_inst_valid=!if_flush.
  - if_flush: drop buffer, go ISSUE.
  - !id_stall: instruction consumed, go ISSUE.
  - Else stay HOLD.
- In every state, if_inst_valid is forced to 0 when if_flush=1.
- Latency: zero-wait memory gives 1 instruction/cycle, with combinational data path imem_data -> if_instruction. N wait cycles give N+1 cycles per instruction. No instruction is ever delivered twice or dropped except on flush.
- No bus request is issued from HOLD or on a flush cycle.

Test Plan:
- Zero-wait stream: rst low 2 cycles, then if_pc=0x0,0x4,0x8, ready every cycle with data 0x11,0x22,0x33. Required: valid each cycle, instructions in order, if_stall=0 throughout.
- Wait states: if_pc=0x100, ready after 3 cycles with data 0xDEADBEEF. Required: imem_address=0x100 stable 4 cycles, if_stall=1 for 3 cycles, then valid with 0xDEADBEEF.
- Decode stall: ready with 0xA5A5A5A5 while id_stall=1 for 3 cycles. Required: HOLD, imem_request=0, if_instruction=0xA5A5A5A5 held, if_stall=1. When id_stall drops, one valid transfer, then the next request is issued.
- Flush during WAIT: request to 0x200 outstanding, if_flush pulse, ready 2 cycles later. Required: address stays 0x200 until ready, data discarded, and the next request is issued to the redirect PC.
- Misaligned: if_pc=0x302. Required: imem_request=0, if_exc_address_if=1, if_instruction=0x00000000, if_inst_valid=1.
- Reset mid-WAIT: rst=0 while a request is outstanding. Required: next cycle imem_request=0, if_inst_valid=0. After release, a fresh fetch is issued from the PC present on if_pc.
